// File: rtl/demux_pkg.sv
// Shared constants and types for the result demux sequencer.
package demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2
    } state_e;

endpackage

// File: rtl/route_fifo.sv
// Synchronous FIFO holding {sel, data} words between the producer and the output stage.
module route_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array: written on accepted push, not reset (contents gated by count)
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointer overflow the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/demux_route_ctrl.sv
// Buffered 1-to-2 result demux with per-destination valid/ready and held outputs.
// Optional macro DEMUX_CNT_EN enables the per-destination transfer counters.
module demux_route_ctrl
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             busy,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH:0]   head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic             push_s;
    logic             pop_s;
    logic             advance_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             a_valid_r;
    logic             b_valid_r;
    logic [WIDTH-1:0] a_data_r;
    logic [WIDTH-1:0] b_data_r;

    // Ready depends only on occupancy, so a full FIFO refuses even in a pop cycle
    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;

    route_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({in_sel, in_data}),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Output-stage next state: the stage frees up when idle or when its destination accepts
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        advance_s   = 1'b0;
        case (state_r)
            ST_EMPTY:  advance_s = 1'b1;
            ST_SEND_A: advance_s = a_ready;
            ST_SEND_B: advance_s = b_ready;
            default:   advance_s = 1'b1;
        endcase
        if (advance_s) begin
            if (!fifo_empty_s) begin
                pop_s = 1'b1;
                if (head_s[WIDTH]) begin
                    state_nxt_s = ST_SEND_A;
                    load_a_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_SEND_B;
                    load_b_s    = 1'b1;
                end
            end else begin
                state_nxt_s = ST_EMPTY;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register with valids registered alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            a_valid_r <= (state_nxt_s == ST_SEND_A);
            b_valid_r <= (state_nxt_s == ST_SEND_B);
        end
    end

    // Output data registers: only the selected side loads, the other holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_r <= WIDTH'(0);
            b_data_r <= WIDTH'(0);
        end else begin
            if (load_a_s) begin
                a_data_r <= head_s[WIDTH-1:0];
            end
            if (load_b_s) begin
                b_data_r <= head_s[WIDTH-1:0];
            end
        end
    end

    assign a_valid = a_valid_r;
    assign b_valid = b_valid_r;
    assign a_data  = a_data_r;
    assign b_data  = b_data_r;
    assign busy    = (fifo_count_s != CW'(0)) || (state_r != ST_EMPTY);

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] a_cnt_r;
    logic [CNT_W-1:0] b_cnt_r;

    // Completed-transfer counters, wrapping naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_r <= 16'd0;
            b_cnt_r <= 16'd0;
        end else begin
            if (a_valid_r && a_ready) begin
                a_cnt_r <= a_cnt_r + 16'd1;
            end
            if (b_valid_r && b_ready) begin
                b_cnt_r <= b_cnt_r + 16'd1;
            end
        end
    end

    assign a_cnt = a_cnt_r;
    assign b_cnt = b_cnt_r;
`else
    assign a_cnt = 16'd0;
    assign b_cnt = 16'd0;
`endif

endmodule
